// File: rtl/lc3_fetch_unit_if.sv
// Memory read bus and decode handshake between the LC-3 fetch unit,
// instruction memory and decode. master = fetch unit side.
interface lc3_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [DATA_W-1:0] ir_out;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rdata,
    input  mem_ready,
    output ir_out,
    output ir_valid,
    input  ir_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rdata,
    output mem_ready,
    input  ir_out,
    input  ir_valid,
    output ir_ready
  );
endinterface

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch sequencer: MAR latch, memory read, IR handoff.
// Define FETCH_TIMEOUT_EN to enable the sticky read-timeout error.
module lc3_fetch_unit #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              run,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              ld_pc,
  output logic [1:0]        pcmux,
  output logic              fetch_err,
  lc3_fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    READ,
    DRAIN,
    HOLD
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] ir_q;
  logic              irv_q;
  logic              rd_act;
  logic              to_hit;

  assign rd_act        = (state_q == READ) || (state_q == DRAIN);
  assign ld_pc         = (state_q == ADDR);
  assign pcmux         = 2'b00;
  assign bus.mem_addr  = mar_q;
  assign bus.mem_rd_en = rd_act;
  assign bus.ir_out    = ir_q;
  assign bus.ir_valid  = irv_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign to_hit    = rd_act && !bus.mem_ready
                     && (cnt_q == LAST);
  assign fetch_err = err_q;

  // Counter restarts on each entry into READ or DRAIN.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (to_hit)
        err_q <= 1'b1;
      if (state_q == ADDR
          || (state_q == READ && flush))
        cnt_q <= '0;
      else if (rd_act && !bus.mem_ready)
        cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign fetch_err = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      ir_q    <= '0;
      irv_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run && !fetch_err)
            state_q <= ADDR;
        end
        ADDR: begin
          mar_q   <= pc_in;
          state_q <= READ;
        end
        READ: begin
          if (to_hit) begin
            state_q <= IDLE;
          end else if (bus.mem_ready) begin
            if (flush) begin
              state_q <= ADDR;
            end else begin
              ir_q    <= bus.mem_rdata;
              irv_q   <= 1'b1;
              state_q <= HOLD;
            end
          end else if (flush) begin
            state_q <= DRAIN;
          end
        end
        // Finish the abandoned read so memory sees a clean handshake.
        DRAIN: begin
          if (to_hit)
            state_q <= IDLE;
          else if (bus.mem_ready)
            state_q <= ADDR;
        end
        HOLD: begin
          if (flush) begin
            irv_q   <= 1'b0;
            state_q <= ADDR;
          end else if (bus.ir_ready) begin
            irv_q   <= 1'b0;
            state_q <= run ? ADDR : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Scoreboard bench for lc3_fetch_unit: fetch, waits, backpressure,
// flush/drain, async reset mid-read and read timeout.
module tb_lc3_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        run;
  logic        flush;
  logic [15:0] pc_in;
  logic        ld_pc;
  logic [1:0]  pcmux;
  logic        fetch_err;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  lc3_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  lc3_fetch_unit #(
    .ADDR_W(16),
    .DATA_W(16),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .run      (run),
    .flush    (flush),
    .pc_in    (pc_in),
    .ld_pc    (ld_pc),
    .pcmux    (pcmux),
    .fetch_err(fetch_err),
    .bus      (bus.master)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      check("ldpc_rden_excl", 32'(ld_pc && bus.mem_rd_en), 0);
      if (bus.ir_valid)
        check("no_dead", 32'(bus.ir_out == 16'hDEAD), 0);
      if (bus.ir_valid && bus.ir_ready && !flush) begin
        if (exp_q.size() == 0)
          check("sb_underflow", 1, 0);
        else
          check("sb_ir", bus.ir_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    Reset         = 1'b1;
    run           = 1'b0;
    flush         = 1'b0;
    pc_in         = 16'h3000;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.ir_ready  = 1'b0;
    #2;
    check("rst_mar", bus.mem_addr, 0);
    check("rst_rden", bus.mem_rd_en, 0);
    check("rst_ir", bus.ir_out, 0);
    check("rst_irv", bus.ir_valid, 0);
    check("rst_ldpc", ld_pc, 0);
    check("rst_pcmux", pcmux, 0);
    check("rst_err", fetch_err, 0);

    @(posedge Clk);
    #7;
    Reset = 1'b0;
    run   = 1'b1;

    // Zero-wait fetch
    tick();
    check("f1_ldpc", ld_pc, 1);
    check("f1_pcmux", pcmux, 0);
    check("f1_rden_addr", bus.mem_rd_en, 0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h1234;
    exp_q.push_back(16'h1234);
    tick();
    check("f1_mar", bus.mem_addr, 16'h3000);
    check("f1_rden", bus.mem_rd_en, 1);
    check("f1_ldpc_rd", ld_pc, 0);
    check("f1_irv_rd", bus.ir_valid, 0);
    tick();
    bus.mem_ready = 1'b0;
    check("f1_irv", bus.ir_valid, 1);
    check("f1_ir", bus.ir_out, 16'h1234);
    check("f1_rden_hold", bus.mem_rd_en, 0);

    // Backpressure in HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ir", bus.ir_out, 16'h1234);
      check("bp_irv", bus.ir_valid, 1);
      check("bp_ldpc", ld_pc, 0);
      check("bp_rden", bus.mem_rd_en, 0);
    end
    pc_in        = 16'h3001;
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;
    check("bp_ldpc_rel", ld_pc, 1);
    check("bp_irv_rel", bus.ir_valid, 0);

    // Three wait states
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h5020;
        exp_q.push_back(16'h5020);
      end
      check("ws_rden", bus.mem_rd_en, 1);
      check("ws_mar", bus.mem_addr, 16'h3001);
      check("ws_irv", bus.ir_valid, 0);
      tick();
    end
    bus.mem_ready = 1'b0;
    check("ws_irv_hold", bus.ir_valid, 1);
    check("ws_ir", bus.ir_out, 16'h5020);
    pc_in        = 16'h3002;
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;
    check("ws_ldpc", ld_pc, 1);

    // Flush during READ, drain, restart at new PC
    tick();
    check("fl_mar", bus.mem_addr, 16'h3002);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pc_in = 16'h4000;
    check("fl_drain_rden", bus.mem_rd_en, 1);
    check("fl_drain_ldpc", ld_pc, 0);
    tick();
    check("fl_drain_rden2", bus.mem_rd_en, 1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    tick();
    bus.mem_ready = 1'b0;
    check("fl_ldpc", ld_pc, 1);
    check("fl_irv", bus.ir_valid, 0);
    tick();
    check("fl_mar_new", bus.mem_addr, 16'h4000);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h1111;
    exp_q.push_back(16'h1111);
    tick();
    bus.mem_ready = 1'b0;
    check("fl_ir", bus.ir_out, 16'h1111);

    // run dropped: finish through HOLD, then IDLE
    run          = 1'b0;
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;
    check("idle_ldpc", ld_pc, 0);
    check("idle_rden", bus.mem_rd_en, 0);
    check("idle_irv", bus.ir_valid, 0);
    tick();
    check("idle_ldpc2", ld_pc, 0);

    // Async reset mid-READ
    run   = 1'b1;
    pc_in = 16'h5000;
    tick();
    tick();
    check("ar_mar", bus.mem_addr, 16'h5000);
    check("ar_rden", bus.mem_rd_en, 1);
    #2;
    Reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    #1;
    check("ar_mar_rst", bus.mem_addr, 0);
    check("ar_rden_rst", bus.mem_rd_en, 0);
    check("ar_ir_rst", bus.ir_out, 0);
    check("ar_irv_rst", bus.ir_valid, 0);
    check("ar_ldpc_rst", ld_pc, 0);
    #1;
    Reset         = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    check("ar_restart", ld_pc, 1);
    tick();
    check("ar_mar2", bus.mem_addr, 16'h5000);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h2222;
    exp_q.push_back(16'h2222);
    tick();
    bus.mem_ready = 1'b0;
    check("ar_ir", bus.ir_out, 16'h2222);
    pc_in        = 16'hFFFF;
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;

    // Stalled read at top of memory
    tick();
    check("to_mar", bus.mem_addr, 16'hFFFF);
    for (int i = 0; i < 15; i++) begin
      check("to_rden", bus.mem_rd_en, 1);
      check("to_err0", fetch_err, 0);
      tick();
    end
`ifdef FETCH_TIMEOUT_EN
    check("to_err", fetch_err, 1);
    check("to_rden_off", bus.mem_rd_en, 0);
    check("to_irv", bus.ir_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_stay_ldpc", ld_pc, 0);
      check("to_stay_rden", bus.mem_rd_en, 0);
      check("to_stay_err", fetch_err, 1);
    end
    run   = 1'b0;
    #2;
    Reset = 1'b1;
    #2;
    check("to_err_clr", fetch_err, 0);
    Reset = 1'b0;
`else
    check("nt_err", fetch_err, 0);
    check("nt_rden", bus.mem_rd_en, 1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h3333;
    exp_q.push_back(16'h3333);
    tick();
    bus.mem_ready = 1'b0;
    check("nt_ir", bus.ir_out, 16'h3333);
    run          = 1'b0;
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;
`endif

    tick();
    tick();
    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
